alu_md_unit: RTL and testbench

Parametrised successor to the combinational ALU decoder. Decodes alu_op/funct3/funct7 (RV32I plus optional RV32M) and executes the operation. Single-cycle ops complete in 1 cycle; MUL*/DIV*/REM* run on an iterative datapath. Sits in the EX stage behind a valid/ready handshake, so the pipeline can stall on multi-cycle ops.

---
 rtl/rv_alu_pkg.sv | 32 +++
 rtl/rv_md_iter.sv | 69 ++++++
 rtl/alu_md_unit.sv | 100 ++++++++++
 tb/tb_alu_md_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_alu_pkg.sv
// rv_alu_pkg: shared ALU control codes, alu_op encodings and FSM states
package rv_alu_pkg;
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_XOR  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_MUL  = 5'd16;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_R   = 2'b10;
  localparam logic [1:0] OP_I   = 2'b11;
  localparam logic [6:0] F7_M   = 7'b0000001;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  function automatic logic [4:0] base_ctrl(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/rv_md_iter.sv
// rv_md_iter: iterative 1-bit/cycle shift-add multiplier and restoring divider
module rv_md_iter import rv_alu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);
  localparam int CW = $clog2(XLEN);
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] hi, lo, d, hi_n, lo_n, ma, mb, quo, rem;
  logic [2:0] op_q;
  logic neg_q, neg_r, na, nb;
  logic [XLEN:0] sum, shl, diff;
  logic [2*XLEN-1:0] prod;
  always_comb begin
    na = a[XLEN-1] & (op[2] ? ~op[0] : ~(op[1] & op[0]));
    nb = b[XLEN-1] & (op[2] ? ~op[0] : ~op[1]);
    ma = na ? -a : a;
    mb = nb ? -b : b;
    sum = {1'b0, hi} + {1'b0, lo[0] ? d : '0};
    shl = {hi, lo[XLEN-1]};
    diff = shl - {1'b0, d};
    hi_n = op_q[2] ? (diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
    lo_n = op_q[2] ? {lo[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo[XLEN-1:1]};
    // sign fixup is applied to the final step's value so the result is ready on the last cycle
    prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    quo = neg_q ? -lo_n : lo_n;
    rem = neg_r ? -hi_n : hi_n;
    res = op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    done = busy & (cnt == CW'(XLEN - 1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      d <= '0;
      op_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (flush) begin
      busy <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      hi <= '0;
      lo <= op[2] ? ma : mb;
      d <= op[2] ? mb : ma;
      op_q <= op;
      neg_q <= na ^ nb;
      neg_r <= na;
    end else if (busy) begin
      hi <= hi_n;
      lo <= lo_n;
      cnt <= cnt + 1'b1;
      busy <= ~done;
    end
  end
endmodule

// File: rtl/alu_md_unit.sv
// alu_md_unit: RV32I/M decode and execute with valid/ready handshake and iterative mul/div
module alu_md_unit import rv_alu_pkg::*; #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1,
  parameter int SHAMT_W  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  state_t state, state_n;
  logic [4:0] ctrl;
  logic ill, accept, is_md, special, one_cycle, md_start, md_busy, md_done, md_fin;
  logic [XLEN-1:0] alu_res, spec_res, res_n, md_res;
  logic [SHAMT_W-1:0] shamt;
  always_comb begin
    ill = 1'b0;
    ctrl = ALU_ADD;
    if (alu_op == OP_ADD) ctrl = ALU_ADD;
    else if (alu_op == OP_SUB) ctrl = ALU_SUB;
    else if (alu_op == OP_R) begin
      if (funct7 == F7_M) begin
        ill = !ENABLE_M;
        ctrl = ENABLE_M ? (ALU_MUL | {2'b00, funct3}) : ALU_ADD;
      end else if (funct7 == 7'b0000000 || funct7 == 7'b0100000) ctrl = base_ctrl(funct3, funct7[5]);
      else ill = 1'b1;
    end else begin
      ctrl = base_ctrl(funct3, funct7[5] & (funct3 == 3'b101));
      ill = (funct3 == 3'b001) && (funct7 != 7'b0000000);
    end
  end
  assign shamt = op_b[SHAMT_W-1:0];
  always_comb begin
    case (ctrl)
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
      ALU_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: alu_res = XLEN'(op_a < op_b);
      default:  alu_res = op_a + op_b;
    endcase
  end
  always_comb begin
    in_ready = (state == S_IDLE) || (state == S_DONE && out_ready);
    accept = in_valid & in_ready & ~flush;
    is_md = ctrl[4] & ~ill;
    special = is_md & ctrl[2] & ((op_b == '0) | (~ctrl[0] & (op_a == MIN) & (op_b == '1)));
    spec_res = (op_b == '0) ? (ctrl[1] ? op_a : '1) : (ctrl[1] ? '0 : op_a);
    res_n = ill ? '0 : special ? spec_res : alu_res;
    one_cycle = ~is_md | special;
    md_start = accept & ~one_cycle;
    md_fin = md_done & md_busy & ~flush;
    out_valid = state == S_DONE;
    state_n = state;
    if (flush) state_n = S_IDLE;
    else if (accept) state_n = one_cycle ? S_DONE : ctrl[2] ? S_DIV : S_MUL;
    else if (md_fin) state_n = S_DONE;
    else if (state == S_DONE && out_ready) state_n = S_IDLE;
  end
  rv_md_iter #(.XLEN(XLEN)) u_md (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(md_start), .op(ctrl[2:0]),
    .a(op_a), .b(op_b), .busy(md_busy), .done(md_done), .res(md_res)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      result <= '0;
      zero <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_n;
      if (accept && one_cycle) begin
        result <= res_n;
        zero <= res_n == '0;
        illegal <= ill;
      end else if (md_fin) begin
        result <= md_res;
        zero <= md_res == '0;
        illegal <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_md_unit.sv
// tb_alu_md_unit: directed and randomized checks of alu_md_unit against a behavioural model
module tb_alu_md_unit;
  localparam logic [31:0] MIN = 32'h8000_0000;
  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, in_valid0 = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [1:0] alu_op = 2'b00;
  logic [2:0] funct3 = 3'b000;
  logic [6:0] funct7 = 7'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic in_ready, out_valid, zero, illegal, in_ready0, out_valid0, zero0, illegal0;
  logic [31:0] result, result0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  alu_md_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );
  alu_md_unit #(.XLEN(32), .ENABLE_M(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .alu_op(alu_op),
    .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b), .flush(flush),
    .out_valid(out_valid0), .out_ready(1'b1), .result(result0), .zero(zero0), .illegal(illegal0)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] base(input logic [2:0] f3, input logic alt, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'b0, sa < $signed(b)};
      3'd3: return {31'b0, a < b};
      3'd4: return a ^ b;
      3'd5: begin
        if (alt) return sa >>> b[4:0];
        return a >> b[4:0];
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction
  task automatic model(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input bit en_m,
                       output logic [31:0] r, output logic ill, output int lat);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    r = '0; ill = 1'b0; lat = 1;
    if (aop == 2'd0) r = a + b;
    else if (aop == 2'd1) r = a - b;
    else if (aop == 2'd2 && f7 == 7'h01) begin
      if (!en_m) ill = 1'b1;
      else begin
        case (f3)
          3'd0: begin p = sa * sb; r = p[31:0]; lat = 33; end
          3'd1: begin p = sa * sb; r = p[63:32]; lat = 33; end
          3'd2: begin p = sa * ub; r = p[63:32]; lat = 33; end
          3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; lat = 33; end
          3'd4: if (b == 0) r = '1; else if (a == MIN && b == '1) r = a; else begin r = 32'(sa / sb); lat = 33; end
          3'd5: if (b == 0) r = '1; else begin r = 32'(ua / ub); lat = 33; end
          3'd6: if (b == 0) r = a; else if (a == MIN && b == '1) r = 0; else begin r = 32'(sa % sb); lat = 33; end
          default: if (b == 0) r = a; else begin r = 32'(ua % ub); lat = 33; end
        endcase
      end
    end else if (aop == 2'd2) begin
      if (f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
      else r = base(f3, f7[5], a, b);
    end else begin
      if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
      else r = base(f3, f3 == 3'd5 && f7[5], a, b);
    end
  endtask
  task automatic run_op(input string tag, input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] er, input logic eill, input int elat);
    int lat, w;
    bit rdy_bad;
    @(negedge clk);
    alu_op = aop; funct3 = f3; funct7 = f7; op_a = a; op_b = b; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 200) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom); funct7 = 7'($urandom);
    lat = 1; rdy_bad = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_res"}, result, er);
    check({tag, "_ill"}, illegal, eill);
    check({tag, "_zero"}, zero, er == 0);
    check({tag, "_lat"}, lat, elat);
    if (elat > 1) check({tag, "_busy_ready"}, rdy_bad, 0);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return '1;
      3: return MIN;
      4: return 32'h7fff_ffff;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction
  task automatic rand_op();
    logic [1:0] aop;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] a, b, r;
    logic ill;
    int lat;
    aop = 2'($urandom); f3 = 3'($urandom); a = pick(); b = pick();
    case ($urandom_range(0, 4))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2, 3: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    model(aop, f3, f7, a, b, 1'b1, r, ill, lat);
    run_op("rand", aop, f3, f7, a, b, r, ill, lat);
  endtask
  task automatic run0(input string tag, input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] er, input logic eill);
    @(negedge clk);
    alu_op = aop; funct3 = f3; funct7 = f7; op_a = a; op_b = b; in_valid0 = 1'b1;
    #1 check({tag, "_ready"}, in_ready0, 1);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    check({tag, "_valid"}, out_valid0, 1);
    check({tag, "_res"}, result0, er);
    check({tag, "_ill"}, illegal0, eill);
    check({tag, "_zero"}, zero0, er == 0);
  endtask
  initial begin
    bit seen;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_illegal", illegal, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("rst_in_ready", in_ready, 1);
    run_op("sub", 2'b10, 3'b000, 7'h20, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
    run_op("addi", 2'b11, 3'b000, 7'h20, 32'd5, 32'd7, 32'd12, 1'b0, 1);
    run_op("sra", 2'b10, 3'b101, 7'h20, MIN, 32'h24, 32'hF800_0000, 1'b0, 1);
    run_op("slt", 2'b10, 3'b010, 7'h00, '1, 32'd1, 32'd1, 1'b0, 1);
    run_op("sltu", 2'b10, 3'b011, 7'h00, '1, 32'd1, 32'd0, 1'b0, 1);
    run_op("mulh", 2'b10, 3'b001, 7'h01, '1, 32'd2, '1, 1'b0, 33);
    run_op("mulhu", 2'b10, 3'b011, 7'h01, '1, 32'd2, 32'd1, 1'b0, 33);
    run_op("div0", 2'b10, 3'b100, 7'h01, 32'd7, 32'd0, '1, 1'b0, 1);
    run_op("rem0", 2'b10, 3'b110, 7'h01, 32'd7, 32'd0, 32'd7, 1'b0, 1);
    run_op("div_ovf", 2'b10, 3'b100, 7'h01, MIN, '1, MIN, 1'b0, 1);
    run_op("rem_ovf", 2'b10, 3'b110, 7'h01, MIN, '1, 32'd0, 1'b0, 1);
    run_op("div_neg", 2'b10, 3'b100, 7'h01, -32'sd7, 32'd2, -32'sd3, 1'b0, 33);
    run_op("rem_neg", 2'b10, 3'b110, 7'h01, -32'sd7, 32'd2, '1, 1'b0, 33);
    run_op("slli_bad", 2'b11, 3'b001, 7'h20, 32'd1, 32'd1, 32'd0, 1'b1, 1);
    run_op("r_bad_f7", 2'b10, 3'b000, 7'h10, 32'd1, 32'd1, 32'd0, 1'b1, 1);
    repeat (2) @(negedge clk);
    out_ready = 1'b0; alu_op = 2'b00; op_a = 32'd3; op_b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = 32'd99;
    repeat (5) begin
      check("bp_valid", out_valid, 1);
      check("bp_result", result, 7);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    alu_op = 2'b01; op_a = 32'd10; op_b = 32'd4; in_valid = 1'b1; out_ready = 1'b1;
    #1 check("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_valid", out_valid, 1);
    check("b2b_result", result, 6);
    repeat (2) @(negedge clk);
    out_ready = 1'b0; alu_op = 2'b00; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; op_a = 32'd5; op_b = 32'd5;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_done_valid", out_valid, 0);
    check("flush_done_idle", in_ready, 1);
    @(negedge clk);
    alu_op = 2'b10; funct3 = 3'b100; funct7 = 7'h01; op_a = 32'd100; op_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_div_idle", in_ready, 1);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    check("flush_div_no_valid", seen, 0);
    run_op("post_flush_mul", 2'b10, 3'b000, 7'h01, 32'd6, 32'd7, 32'd42, 1'b0, 33);
    run_op("pre_rst_add", 2'b00, 3'b000, 7'h00, 32'd1, 32'd1, 32'd2, 1'b0, 1);
    @(negedge clk);
    alu_op = 2'b10; funct3 = 3'b000; funct7 = 7'h01; op_a = 32'd3; op_b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mul_valid", out_valid, 0);
    check("rst_mul_result", result, 0);
    check("rst_mul_zero", zero, 0);
    check("rst_mul_illegal", illegal, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    check("rst_mul_no_valid", seen, 0);
    run0("m_off_add", 2'b00, 3'b000, 7'h00, 32'd3, 32'd4, 32'd7, 1'b0);
    run0("m_off_mul", 2'b10, 3'b000, 7'h01, 32'd3, 32'd4, 32'd0, 1'b1);
    for (int i = 0; i < 150; i++) rand_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
